// File: rtl/acq_pkg.sv
// Shared constants for the acquisition burst scheduler and acquisition block.
// Holds FSM state encodings, stream marker words and a small state helper.
package acq_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_RUN   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_DONE  = 3'd3;
  localparam logic [2:0] ST_ERROR = 3'd4;

  localparam logic [31:0] HEADER     = 32'hCAFE_0001;
  localparam logic [31:0] FOOTER     = 32'hCAFE_00FF;
  localparam logic [31:0] TLAST_MARK = 32'hCAFE_1A57;

  function automatic logic is_busy(input logic [2:0] s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/acq_watchdog.sv
// Stream stall watchdog: counts idle cycles while active, cleared by beats.
// Ports: master_clock, resetn, active, beat, limit (0 = off), expire.
module acq_watchdog #(
  parameter int W = 24
) (
  input  logic         master_clock,
  input  logic         resetn,
  input  logic         active,
  input  logic         beat,
  input  logic [W-1:0] limit,
  output logic         expire
);

  logic [W-1:0] cnt;
  logic [W-1:0] lim_m1;

  assign lim_m1 = limit - 1'b1;

  always_ff @(posedge master_clock) begin
    if (!resetn || !active || beat) begin
      cnt <= '0;
    end else if (cnt != '1) begin
      cnt <= cnt + 1'b1;
    end
  end

  // A beat in the limit cycle keeps the stream alive.
  assign expire = active && (limit != '0) &&
                  (cnt >= lim_m1) && !beat;

endmodule

// File: rtl/acq_burst_scheduler.sv
// Burst scheduler: gates acquisition, shadows config at burst starts,
// enforces start-to-start period, counts bursts, watchdogs the stream.
// Ports: cfg_* control in, mon_* stream monitor in, acq/status out.
module acq_burst_scheduler
  import acq_pkg::*;
#(
  parameter int PERIOD_W  = 32,
  parameter int TIMEOUT_W = 24,
  parameter int BURST_W   = 16
) (
  input  logic                 master_clock,
  input  logic                 resetn,
  input  logic                 cfg_start,
  input  logic                 cfg_stop,
  input  logic                 cfg_clear_err,
  input  logic                 cfg_raw_mode,
  input  logic [15:0]          cfg_num_packets,
  input  logic [PERIOD_W-1:0]  cfg_period,
  input  logic [BURST_W-1:0]   cfg_num_bursts,
  input  logic [TIMEOUT_W-1:0] cfg_timeout,
  input  logic                 mon_tvalid,
  input  logic                 mon_tready,
  input  logic                 mon_tlast,
  output logic                 acq_enable,
  output logic                 send_raw_data,
  output logic [15:0]          number_of_packet,
  output logic                 busy,
  output logic [BURST_W-1:0]   burst_count,
  output logic                 done_pulse,
  output logic                 err_timeout,
  output logic [2:0]           dbg_state
);

  logic [2:0]          state;
  logic [2:0]          nxt;
  logic [BURST_W-1:0]  nb_q;
  logic [PERIOD_W-1:0] period_cnt;
  logic [PERIOD_W:0]   period_inc;
  logic                stop_pending;
  logic                beat;
  logic                burst_end;
  logic                last_burst;
  logic                period_hit;
  logic                wd_expire;
  logic                in_run;
  logic                start_ok;
  logic                relaunch;

  assign beat      = mon_tvalid & mon_tready;
  assign burst_end = beat & mon_tlast;
  assign in_run    = state == ST_RUN;

  assign last_burst = (nb_q != '0) &&
                      (burst_count + 1'b1 == nb_q);

  // Extra bit keeps the +1 from wrapping at all-ones.
  assign period_inc = {1'b0, period_cnt} + 1'b1;
  assign period_hit = period_inc >= {1'b0, cfg_period};

  assign start_ok = (state == ST_IDLE) &&
                    cfg_start && !cfg_stop;
  assign relaunch = (state == ST_WAIT) &&
                    !cfg_stop && period_hit;

  acq_watchdog #(
    .W (TIMEOUT_W)
  ) u_wd (
    .master_clock (master_clock),
    .resetn       (resetn),
    .active       (in_run),
    .beat         (beat),
    .limit        (cfg_timeout),
    .expire       (wd_expire)
  );

  always_comb begin
    nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (start_ok) nxt = ST_RUN;
      end
      ST_RUN: begin
        if (wd_expire) begin
          nxt = ST_ERROR;
        end else if (burst_end) begin
          if (last_burst || stop_pending || cfg_stop)
            nxt = ST_DONE;
          else
            nxt = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cfg_stop)        nxt = ST_DONE;
        else if (period_hit) nxt = ST_RUN;
      end
      ST_DONE: begin
        nxt = ST_IDLE;
      end
      ST_ERROR: begin
        if (cfg_clear_err) nxt = ST_IDLE;
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge master_clock) begin
    if (!resetn) begin
      state            <= ST_IDLE;
      nb_q             <= '0;
      send_raw_data    <= 1'b0;
      number_of_packet <= '0;
      burst_count      <= '0;
      period_cnt       <= '0;
      stop_pending     <= 1'b0;
    end else begin
      state <= nxt;

      if (start_ok || relaunch) begin
        send_raw_data    <= cfg_raw_mode;
        number_of_packet <= cfg_num_packets;
        period_cnt       <= '0;
      end else if (in_run || state == ST_WAIT) begin
        if (period_cnt != '1)
          period_cnt <= period_cnt + 1'b1;
      end

      if (start_ok) begin
        nb_q        <= cfg_num_bursts;
        burst_count <= '0;
      end else if (in_run && burst_end) begin
        burst_count <= burst_count + 1'b1;
      end

      if (nxt == ST_IDLE)
        stop_pending <= 1'b0;
      else if (in_run && cfg_stop)
        stop_pending <= 1'b1;
    end
  end

  assign acq_enable  = in_run;
  assign busy        = is_busy(state);
  assign done_pulse  = state == ST_DONE;
  assign err_timeout = state == ST_ERROR;
  assign dbg_state   = state;

endmodule

// File: tb/tb_acq_burst_scheduler.sv
// Scoreboard bench for acq_burst_scheduler.
// Stimulus queues expected events; a negedge monitor pops and compares.
module tb_acq_burst_scheduler;

  logic        master_clock;
  logic        resetn;
  logic        cfg_start;
  logic        cfg_stop;
  logic        cfg_clear_err;
  logic        cfg_raw_mode;
  logic [15:0] cfg_num_packets;
  logic [31:0] cfg_period;
  logic [15:0] cfg_num_bursts;
  logic [23:0] cfg_timeout;
  logic        mon_tvalid;
  logic        mon_tready;
  logic        mon_tlast;
  logic        acq_enable;
  logic        send_raw_data;
  logic [15:0] number_of_packet;
  logic        busy;
  logic [15:0] burst_count;
  logic        done_pulse;
  logic        err_timeout;
  logic [2:0]  dbg_state;

  acq_burst_scheduler dut (
    .master_clock     (master_clock),
    .resetn           (resetn),
    .cfg_start        (cfg_start),
    .cfg_stop         (cfg_stop),
    .cfg_clear_err    (cfg_clear_err),
    .cfg_raw_mode     (cfg_raw_mode),
    .cfg_num_packets  (cfg_num_packets),
    .cfg_period       (cfg_period),
    .cfg_num_bursts   (cfg_num_bursts),
    .cfg_timeout      (cfg_timeout),
    .mon_tvalid       (mon_tvalid),
    .mon_tready       (mon_tready),
    .mon_tlast        (mon_tlast),
    .acq_enable       (acq_enable),
    .send_raw_data    (send_raw_data),
    .number_of_packet (number_of_packet),
    .busy             (busy),
    .burst_count      (burst_count),
    .done_pulse       (done_pulse),
    .err_timeout      (err_timeout),
    .dbg_state        (dbg_state)
  );

  initial master_clock = 1'b0;
  always #12 master_clock = ~master_clock;

  int cyc = 0;
  always @(posedge master_clock) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    int          cyc;
    logic        raw;
    logic [15:0] npkt;
  } rise_t;

  typedef struct {
    int          cyc;
    logic [15:0] bc;
  } done_t;

  rise_t q_rise[$];
  int    q_fall[$];
  done_t q_done[$];
  int    q_err[$];

  task automatic chk(input string nm,
                     input longint act,
                     input longint exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d (cyc %0d)",
               nm, act, exp, cyc);
    end
  endtask

  // Monitor: every DUT event must match the head of its queue.
  logic prev_en  = 1'b0;
  logic prev_err = 1'b0;
  always @(negedge master_clock) begin : mon
    rise_t r;
    done_t d;
    int    c;
    if (acq_enable === 1'b1 && !prev_en) begin
      chk("rise_expected", q_rise.size() != 0, 1);
      if (q_rise.size() != 0) begin
        r = q_rise.pop_front();
        chk("rise_cyc", cyc, r.cyc);
        chk("rise_raw", send_raw_data, r.raw);
        chk("rise_npkt", number_of_packet, r.npkt);
      end
    end
    if (acq_enable === 1'b0 && prev_en) begin
      chk("fall_expected", q_fall.size() != 0, 1);
      if (q_fall.size() != 0) begin
        c = q_fall.pop_front();
        chk("fall_cyc", cyc, c);
      end
    end
    if (done_pulse === 1'b1) begin
      chk("done_expected", q_done.size() != 0, 1);
      if (q_done.size() != 0) begin
        d = q_done.pop_front();
        chk("done_cyc", cyc, d.cyc);
        chk("done_bc", burst_count, d.bc);
      end
    end
    if (err_timeout === 1'b1 && !prev_err) begin
      chk("err_expected", q_err.size() != 0, 1);
      if (q_err.size() != 0) begin
        c = q_err.pop_front();
        chk("err_cyc", cyc, c);
      end
    end
    prev_en  = (acq_enable === 1'b1);
    prev_err = (err_timeout === 1'b1);
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge master_clock);
      #1;
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    tick(1);
    cfg_start = 1'b0;
  endtask

  task automatic pulse_stop();
    cfg_stop = 1'b1;
    tick(1);
    cfg_stop = 1'b0;
  endtask

  task automatic beat(input logic last);
    mon_tvalid = 1'b1;
    mon_tready = 1'b1;
    mon_tlast  = last;
    tick(1);
    mon_tvalid = 1'b0;
    mon_tready = 1'b0;
    mon_tlast  = 1'b0;
  endtask

  task automatic drain(input string nm);
    tick(3);
    chk({nm, "_rise_left"}, q_rise.size(), 0);
    chk({nm, "_fall_left"}, q_fall.size(), 0);
    chk({nm, "_done_left"}, q_done.size(), 0);
    chk({nm, "_err_left"},  q_err.size(), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: got hang required finish");
    $fatal(1);
  end

  int t0;

  initial begin
    resetn          = 1'b0;
    cfg_start       = 1'b0;
    cfg_stop        = 1'b0;
    cfg_clear_err   = 1'b0;
    cfg_raw_mode    = 1'b0;
    cfg_num_packets = 16'd0;
    cfg_period      = 32'd0;
    cfg_num_bursts  = 16'd0;
    cfg_timeout     = 24'd0;
    mon_tvalid      = 1'b0;
    mon_tready      = 1'b0;
    mon_tlast       = 1'b0;
    tick(2);
    chk("rst_en",    acq_enable, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done_pulse, 0);
    chk("rst_err",   err_timeout, 0);
    chk("rst_bc",    burst_count, 0);
    chk("rst_raw",   send_raw_data, 0);
    chk("rst_npkt",  number_of_packet, 0);
    chk("rst_state", dbg_state, 0);
    resetn = 1'b1;
    tick(2);

    // Single burst, tlast at cycle 50.
    cfg_num_bursts  = 16'd1;
    cfg_num_packets = 16'd7;
    t0 = cyc;
    q_rise.push_back(rise_t'{cyc: t0 + 1, raw: 1'b0, npkt: 16'd7});
    q_fall.push_back(t0 + 51);
    q_done.push_back(done_t'{cyc: t0 + 51, bc: 16'd1});
    pulse_start();
    wait_to(t0 + 50);
    beat(1'b1);
    tick(1);
    chk("single_busy", busy, 0);
    chk("single_bc", burst_count, 1);
    drain("single");

    // Periodic run: period 200, 3 bursts of 80 cycles.
    cfg_period      = 32'd200;
    cfg_num_bursts  = 16'd3;
    cfg_num_packets = 16'd3;
    t0 = cyc;
    q_rise.push_back(rise_t'{cyc: t0 + 1,   raw: 1'b0, npkt: 16'd3});
    q_rise.push_back(rise_t'{cyc: t0 + 201, raw: 1'b0, npkt: 16'd9});
    q_rise.push_back(rise_t'{cyc: t0 + 401, raw: 1'b0, npkt: 16'd9});
    q_fall.push_back(t0 + 81);
    q_fall.push_back(t0 + 281);
    q_fall.push_back(t0 + 481);
    q_done.push_back(done_t'{cyc: t0 + 481, bc: 16'd3});
    pulse_start();
    wait_to(t0 + 20);
    cfg_num_packets = 16'd9;
    chk("per_npkt_held", number_of_packet, 3);
    wait_to(t0 + 80);
    beat(1'b1);
    wait_to(t0 + 150);
    chk("per_wait_busy", busy, 1);
    chk("per_wait_state", dbg_state, 2);
    wait_to(t0 + 280);
    beat(1'b1);
    wait_to(t0 + 480);
    beat(1'b1);
    drain("periodic");

    // Stop mid-burst in continuous mode.
    cfg_period      = 32'd0;
    cfg_num_bursts  = 16'd0;
    cfg_num_packets = 16'd5;
    t0 = cyc;
    q_rise.push_back(rise_t'{cyc: t0 + 1, raw: 1'b0, npkt: 16'd5});
    q_fall.push_back(t0 + 61);
    q_done.push_back(done_t'{cyc: t0 + 61, bc: 16'd1});
    pulse_start();
    wait_to(t0 + 30);
    pulse_stop();
    wait_to(t0 + 45);
    chk("stop_en_held", acq_enable, 1);
    wait_to(t0 + 60);
    beat(1'b1);
    tick(1);
    chk("stop_busy", busy, 0);
    chk("stop_bc", burst_count, 1);
    drain("stop");

    // Stop while waiting for the next period.
    cfg_period = 32'd100;
    t0 = cyc;
    q_rise.push_back(rise_t'{cyc: t0 + 1, raw: 1'b0, npkt: 16'd5});
    q_fall.push_back(t0 + 21);
    q_done.push_back(done_t'{cyc: t0 + 41, bc: 16'd1});
    pulse_start();
    wait_to(t0 + 20);
    beat(1'b1);
    wait_to(t0 + 40);
    pulse_stop();
    wait_to(t0 + 150);
    chk("wstop_state", dbg_state, 0);
    drain("wstop");

    // Watchdog: one beat at cycle 10, then stall.
    cfg_period  = 32'd0;
    cfg_timeout = 24'd100;
    t0 = cyc;
    q_rise.push_back(rise_t'{cyc: t0 + 1, raw: 1'b0, npkt: 16'd5});
    q_fall.push_back(t0 + 111);
    q_err.push_back(t0 + 111);
    pulse_start();
    wait_to(t0 + 10);
    beat(1'b0);
    wait_to(t0 + 130);
    pulse_start();
    tick(1);
    chk("wd_state", dbg_state, 4);
    chk("wd_err", err_timeout, 1);
    chk("wd_en", acq_enable, 0);
    chk("wd_busy", busy, 1);
    cfg_clear_err = 1'b1;
    tick(1);
    cfg_clear_err = 1'b0;
    chk("wd_clr_state", dbg_state, 0);
    chk("wd_clr_err", err_timeout, 0);
    cfg_timeout = 24'd0;
    drain("wd");

    // Shadow raw-mode change mid-burst.
    cfg_num_bursts  = 16'd2;
    cfg_num_packets = 16'd4;
    cfg_raw_mode    = 1'b0;
    t0 = cyc;
    q_rise.push_back(rise_t'{cyc: t0 + 1,  raw: 1'b0, npkt: 16'd4});
    q_rise.push_back(rise_t'{cyc: t0 + 32, raw: 1'b1, npkt: 16'd4});
    q_fall.push_back(t0 + 31);
    q_fall.push_back(t0 + 51);
    q_done.push_back(done_t'{cyc: t0 + 51, bc: 16'd2});
    pulse_start();
    wait_to(t0 + 10);
    cfg_raw_mode = 1'b1;
    wait_to(t0 + 15);
    chk("shadow_raw_held", send_raw_data, 0);
    wait_to(t0 + 30);
    beat(1'b1);
    wait_to(t0 + 40);
    chk("shadow_raw_new", send_raw_data, 1);
    wait_to(t0 + 50);
    beat(1'b1);
    drain("shadow");

    // Reset at cycle 40 of a run.
    cfg_num_bursts  = 16'd0;
    cfg_num_packets = 16'd2;
    t0 = cyc;
    q_rise.push_back(rise_t'{cyc: t0 + 1, raw: 1'b1, npkt: 16'd2});
    q_fall.push_back(t0 + 41);
    pulse_start();
    wait_to(t0 + 40);
    resetn = 1'b0;
    tick(1);
    chk("mrst_en",    acq_enable, 0);
    chk("mrst_busy",  busy, 0);
    chk("mrst_done",  done_pulse, 0);
    chk("mrst_raw",   send_raw_data, 0);
    chk("mrst_npkt",  number_of_packet, 0);
    chk("mrst_state", dbg_state, 0);
    resetn = 1'b1;
    tick(5);
    drain("mrst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
